pcss_stream_sched: RTL and testbench

Session scheduler that owns the single 64-bit AXI-stream send port of the PCSS chip interface and shares it between a configuration source and a spike source. Sequences one run: stream `cfg_len` config words, wait for the chip's all-ones completion word on the receive stream, then release one spike frame per tik period until `frames` frames are sent. Sits between the host DMA streams and the interface block's `S_AXIS_send_*` port; passively monitors `M_AXIS_recv_*` and `tik`.

---
 rtl/pcss_stream_sched.sv | 209 ++++++++++++++++++++
 tb/tb_pcss_stream_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcss_stream_sched.sv
// Session scheduler for the PCSS send stream: streams config words, waits for the chip's
// all-ones completion word, then releases one spike frame per tik period.
module pcss_stream_sched #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_W      = 20,
  parameter int unsigned FRM_W      = 8,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [FRM_W-1:0]        frames,
  input  logic [DATA_WIDTH-1:0]   cfg_tdata,
  input  logic                    cfg_tvalid,
  output logic                    cfg_tready,
  input  logic [DATA_WIDTH-1:0]   spk_tdata,
  input  logic                    spk_tvalid,
  input  logic                    spk_tlast,
  output logic                    spk_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  input  logic                    m_tready,
  input  logic [DATA_WIDTH-1:0]   recv_tdata,
  input  logic                    recv_tvalid,
  input  logic                    recv_tready,
  input  logic                    tik,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [FRM_W-1:0]        frame_cnt,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCfg     = 3'd1,
    StCfgAck  = 3'd2,
    StRun     = 3'd3,
    StWaitTik = 3'd4,
    StDone    = 3'd5,
    StErr     = 3'd6
  } state_e;

  // Counter only needs to hold TIMEOUT-1: expiry is detected as the increment that reaches TIMEOUT
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_e           state_q;
  state_e           start_state;
  logic [LEN_W-1:0] cfg_len_q;
  logic [LEN_W-1:0] beat_q;
  logic [FRM_W-1:0] frames_q;
  logic [FRM_W-1:0] frame_cnt_q;
  logic [FRM_W-1:0] frame_inc;
  logic [TmoW-1:0]  tmo_q;
  logic             done_q;
  logic             timeout_err_q;
  logic             tik_q;

  logic cfg_last;
  logic beat_fire;
  logic ack_seen;
  logic tik_fall;

  assign cfg_last  = (beat_q == cfg_len_q - LEN_W'(1));
  assign beat_fire = m_tvalid & m_tready;
  assign ack_seen  = recv_tvalid & recv_tready & (&recv_tdata);
  assign tik_fall  = tik_q & ~tik;
  assign frame_inc = frame_cnt_q + FRM_W'(1);

  always_comb begin
    if (cfg_len != '0) begin
      start_state = StCfg;
    end else if (frames != '0) begin
      start_state = StRun;
    end else begin
      start_state = StDone;
    end
  end

  always_comb begin
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tlast    = 1'b0;
    cfg_tready = 1'b0;
    spk_tready = 1'b0;
    case (state_q)
      StCfg: begin
        // abort drops valid at once; the host flushes whatever the source still holds
        m_tvalid   = cfg_tvalid & ~abort;
        m_tdata    = cfg_tdata;
        m_tlast    = cfg_last;
        cfg_tready = m_tready;
      end
      StRun: begin
        m_tvalid   = spk_tvalid & ~abort;
        m_tdata    = spk_tdata;
        m_tlast    = spk_tlast;
        spk_tready = m_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cfg_len_q     <= '0;
      frames_q      <= '0;
      beat_q        <= '0;
      frame_cnt_q   <= '0;
      tmo_q         <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tik_q         <= 1'b0;
    end else begin
      tik_q  <= tik;
      done_q <= 1'b0;
      if (abort) begin
        state_q       <= StIdle;
        frame_cnt_q   <= '0;
        timeout_err_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StErr: begin
            if (start) begin
              cfg_len_q     <= cfg_len;
              frames_q      <= frames;
              beat_q        <= '0;
              frame_cnt_q   <= '0;
              tmo_q         <= '0;
              timeout_err_q <= 1'b0;
              state_q       <= start_state;
              done_q        <= (start_state == StDone);
            end
          end
          StCfg: begin
            if (beat_fire) begin
              if (cfg_last) begin
                state_q <= StCfgAck;
                tmo_q   <= '0;
              end else begin
                beat_q <= beat_q + LEN_W'(1);
              end
            end
          end
          StCfgAck: begin
            // an ack arriving on the expiry cycle still wins
            if (ack_seen) begin
              state_q <= (frames_q != '0) ? StRun : StDone;
              done_q  <= (frames_q == '0);
            end else if (tmo_q == TmoLast) begin
              state_q       <= StErr;
              timeout_err_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TmoW'(1);
            end
          end
          StRun: begin
            if (beat_fire && spk_tlast) begin
              frame_cnt_q <= frame_inc;
              if (frame_inc == frames_q) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StWaitTik;
              end
            end
          end
          StWaitTik: begin
            if (tik_fall) begin
              state_q <= StRun;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign m_tkeep     = '1;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign state       = state_q;

  a_quiet_outside_data: assert property (@(posedge clk) disable iff (rst)
    !(state_q inside {StCfg, StRun}) |-> !(m_tvalid | cfg_tready | spk_tready));

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  a_err_flag_in_err: assert property (@(posedge clk) disable iff (rst)
    timeout_err |-> (state_q == StErr));

  a_frame_bound: assert property (@(posedge clk) disable iff (rst)
    frame_cnt_q <= frames_q);

endmodule

// File: tb/tb_pcss_stream_sched.sv
// Self-checking bench for pcss_stream_sched: session-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized sessions.
module tb_pcss_stream_sched;
  localparam int DW  = 64;
  localparam int LW  = 20;
  localparam int FW  = 8;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [FW-1:0] frames = '0;
  logic [DW-1:0] cfg_tdata = '0;
  logic          cfg_tvalid = 1'b0;
  logic          cfg_tready;
  logic [DW-1:0] spk_tdata = '0;
  logic          spk_tvalid = 1'b0;
  logic          spk_tlast = 1'b0;
  logic          spk_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [7:0]    m_tkeep;
  logic          m_tready = 1'b1;
  logic [DW-1:0] recv_tdata = '0;
  logic          recv_tvalid = 1'b0;
  logic          recv_tready = 1'b0;
  logic          tik = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  pcss_stream_sched #(
    .DATA_WIDTH(DW),
    .LEN_W     (LW),
    .FRM_W     (FW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_len    (cfg_len),
    .frames     (frames),
    .cfg_tdata  (cfg_tdata),
    .cfg_tvalid (cfg_tvalid),
    .cfg_tready (cfg_tready),
    .spk_tdata  (spk_tdata),
    .spk_tvalid (spk_tvalid),
    .spk_tlast  (spk_tlast),
    .spk_tready (spk_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tkeep    (m_tkeep),
    .m_tready   (m_tready),
    .recv_tdata (recv_tdata),
    .recv_tvalid(recv_tvalid),
    .recv_tready(recv_tready),
    .tik        (tik),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
    end
  endfunction

  // Session-level reference: phase numbers are the published state encoding
  int ms = 0, mbeat = 0, mcl = 0, mfr = 0, mfc = 0, mwait = 0;
  bit mterr = 1'b0, mtik = 1'b0;

  int n_done = 0, n_cfg_beats = 0, n_cfg_last = 0, n_frames_out = 0, n_mbeats = 0;
  bit cfg_hs = 1'b0, spk_hs = 1'b0;

  always @(negedge clk) begin : mon
    logic          ev, el, ecr, esr;
    logic [DW-1:0] ed;
    bit            hs, ack, tfall;
    ev = 1'b0; el = 1'b0; ecr = 1'b0; esr = 1'b0; ed = '0;
    if (ms == 1) begin
      ev = cfg_tvalid && !abort; ed = cfg_tdata; el = (mbeat == mcl - 1); ecr = m_tready;
    end else if (ms == 3) begin
      ev = spk_tvalid && !abort; ed = spk_tdata; el = spk_tlast; esr = m_tready;
    end
    chk("state", 64'(state), 64'(ms));
    chk("busy", 64'(busy), 64'(ms != 0));
    chk("done", 64'(done), 64'(ms == 5));
    chk("timeout_err", 64'(timeout_err), 64'(mterr));
    chk("frame_cnt", 64'(frame_cnt), 64'(mfc));
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    chk("m_tlast", 64'(m_tlast), 64'(el));
    chk("m_tdata", m_tdata, ed);
    chk("cfg_tready", 64'(cfg_tready), 64'(ecr));
    chk("spk_tready", 64'(spk_tready), 64'(esr));
    chk("m_tkeep", 64'(m_tkeep), 64'hFF);

    if (done) n_done++;
    if (m_tvalid && m_tready) begin
      n_mbeats++;
      if (state == 3'd1) begin
        n_cfg_beats++;
        if (m_tlast) n_cfg_last++;
      end
      if (state == 3'd3 && m_tlast) n_frames_out++;
    end
    cfg_hs = cfg_tvalid && cfg_tready;
    spk_hs = spk_tvalid && spk_tready;

    hs    = ev && m_tready;
    ack   = recv_tvalid && recv_tready && (recv_tdata == '1);
    tfall = mtik && !tik;
    if (rst) begin
      ms = 0; mfc = 0; mterr = 1'b0; mtik = 1'b0;
    end else begin
      mtik = tik;
      if (abort) begin
        ms = 0; mfc = 0; mterr = 1'b0;
      end else begin
        case (ms)
          0, 6: if (start) begin
            mcl = int'(cfg_len); mfr = int'(frames); mfc = 0; mbeat = 0; mterr = 1'b0;
            ms = (cfg_len != 0) ? 1 : (frames != 0) ? 3 : 5;
          end
          1: if (hs) begin
            mbeat++;
            if (mbeat == mcl) begin ms = 2; mwait = 0; end
          end
          2: if (ack) begin
            ms = (mfr != 0) ? 3 : 5;
          end else begin
            mwait++;
            if (mwait == TMO) begin ms = 6; mterr = 1'b1; end
          end
          3: if (hs && spk_tlast) begin
            mfc++;
            ms = (mfc == mfr) ? 5 : 4;
          end
          4: if (tfall) ms = 3;
          5: ms = 0;
          default: ms = 0;
        endcase
      end
    end
  end

  // Stimulus knobs
  bit cfg_en = 1'b1, spk_en = 1'b1, rcv_rand = 1'b0;
  int cfg_vp = 100, rdy_mode = 0, tik_mode = 0, cyc = 0;
  int spk_idx = 0, spk_len = 1;

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (cfg_hs) cfg_tvalid = 1'b0;
    if (!cfg_en) cfg_tvalid = 1'b0;
    else if (!cfg_tvalid && $urandom_range(0, 99) < cfg_vp) begin
      cfg_tvalid = 1'b1; cfg_tdata = {$urandom, $urandom};
    end
    if (spk_hs) begin
      spk_tvalid = 1'b0;
      if (spk_tlast) begin spk_idx = 0; spk_len = $urandom_range(1, 3); end
      else spk_idx++;
    end
    if (!spk_en) spk_tvalid = 1'b0;
    else if (!spk_tvalid && $urandom_range(0, 99) < cfg_vp) begin
      spk_tvalid = 1'b1; spk_tdata = {$urandom, $urandom}; spk_tlast = (spk_idx == spk_len - 1);
    end
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = !m_tready;
      2: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
    case (tik_mode)
      1: tik = ((cyc % 8) < 4);
      2: tik = 1'($urandom_range(0, 1));
      default: ;
    endcase
    if (rcv_rand) begin
      recv_tvalid = ($urandom_range(0, 3) == 0);
      recv_tready = 1'($urandom_range(0, 1));
      recv_tdata  = recv_tready ? {32'h0, $urandom} : '1;
    end else begin
      recv_tvalid = 1'b0; recv_tready = 1'b0; recv_tdata = '0;
    end
  endtask

  task automatic do_start(input int cl, input int fr);
    cfg_len = LW'(cl); frames = FW'(fr); start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic ack_pulse();
    recv_tvalid = 1'b1; recv_tready = 1'b1; recv_tdata = '1;
    cycle();
  endtask

  task automatic wait_state(input int tgt, input int budget, input string nm, output int n);
    n = 0;
    while (int'(state) != tgt && n < budget) begin
      cycle();
      n++;
    end
    chk(nm, 64'(state), 64'(tgt));
  endtask

  task automatic clear_stats();
    n_done = 0; n_cfg_beats = 0; n_cfg_last = 0; n_frames_out = 0; n_mbeats = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog at %0t: got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, ack_at;
    bit fin;
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tkeep", 64'(m_tkeep), 64'hFF);

    // Basic session: 3 config beats, 2 tik-paced frames
    clear_stats(); tik_mode = 1;
    do_start(3, 2);
    wait_state(2, 20, "s1_cfgack", n);
    repeat (5) cycle();
    ack_pulse();
    chk("s1_run", 64'(state), 64'd3);
    wait_state(5, 200, "s1_done_state", n);
    chk("s1_done", 64'(done), 64'd1);
    cycle();
    chk("s1_idle", 64'(state), 64'd0);
    repeat (3) cycle();
    chk("s1_cfg_beats", 64'(n_cfg_beats), 64'd3);
    chk("s1_cfg_last", 64'(n_cfg_last), 64'd1);
    chk("s1_frames", 64'(n_frames_out), 64'd2);
    chk("s1_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("s1_done_cnt", 64'(n_done), 64'd1);

    // Backpressure: m_tready toggles every cycle
    clear_stats(); rdy_mode = 1; cfg_vp = 70; tik_mode = 2;
    do_start(7, 3);
    wait_state(2, 100, "s2_cfgack", n);
    ack_pulse();
    wait_state(0, 400, "s2_idle", n);
    chk("s2_cfg_beats", 64'(n_cfg_beats), 64'd7);
    chk("s2_cfg_last", 64'(n_cfg_last), 64'd1);
    chk("s2_frames", 64'(n_frames_out), 64'd3);
    chk("s2_done_cnt", 64'(n_done), 64'd1);

    // Timeout with no ack
    rdy_mode = 0; cfg_vp = 100; tik_mode = 1;
    do_start(2, 1);
    wait_state(2, 20, "s3_cfgack", n);
    wait_state(6, 40, "s3_err", n);
    chk("s3_tmo_cycles", 64'(n), 64'd20);
    chk("s3_terr", 64'(timeout_err), 64'd1);
    repeat (3) cycle();
    chk("s3_hold", 64'(state), 64'd6);
    do_start(0, 0);
    chk("s3_clear", 64'(timeout_err), 64'd0);
    cycle();
    chk("s3_idle", 64'(state), 64'd0);

    // Empty session
    clear_stats();
    do_start(0, 0);
    chk("s4_done_state", 64'(state), 64'd5);
    chk("s4_done", 64'(done), 64'd1);
    cycle();
    chk("s4_idle", 64'(state), 64'd0);
    repeat (2) cycle();
    chk("s4_done_cnt", 64'(n_done), 64'd1);
    chk("s4_beats", 64'(n_mbeats), 64'd0);

    // Non-ack receive word is ignored
    do_start(1, 1);
    wait_state(2, 20, "s5_cfgack", n);
    recv_tvalid = 1'b1; recv_tready = 1'b1; recv_tdata = 64'h1234;
    cycle();
    chk("s5_ignore", 64'(state), 64'd2);
    ack_pulse();
    chk("s5_run", 64'(state), 64'd3);
    wait_state(0, 100, "s5_idle", n);

    // Abort mid-RUN after one frame
    do_start(0, 5);
    n = 0;
    while (!(frame_cnt == 8'd1 && state == 3'd3) && n < 300) begin cycle(); n++; end
    chk("s6_setup", 64'(frame_cnt), 64'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("s6_state", 64'(state), 64'd0);
    chk("s6_mvalid", 64'(m_tvalid), 64'd0);
    chk("s6_fc", 64'(frame_cnt), 64'd0);

    // tik edge during CFG ignored, then reset mid-CFG
    tik_mode = 0; tik = 1'b0; rdy_mode = 1;
    do_start(10, 1);
    chk("s7_cfg", 64'(state), 64'd1);
    tik = 1'b1; cycle();
    tik = 1'b0; cycle(); cycle();
    chk("s7_tik_ignored", 64'(state), 64'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("s7_state", 64'(state), 64'd0);
    chk("s7_mvalid", 64'(m_tvalid), 64'd0);
    chk("s7_busy", 64'(busy), 64'd0);
    chk("s7_fc", 64'(frame_cnt), 64'd0);

    // Falling edge seen in RUN is not queued for WAIT_TIK
    rdy_mode = 0; spk_en = 1'b0;
    do_start(0, 2);
    tik = 1'b1; cycle();
    tik = 1'b0; cycle();
    spk_en = 1'b1;
    wait_state(4, 50, "s8_wait", n);
    repeat (6) cycle();
    chk("s8_noqueue", 64'(state), 64'd4);
    tik = 1'b1; cycle();
    tik = 1'b0; cycle();
    chk("s8_release", 64'(state), 64'd3);
    wait_state(0, 100, "s8_idle", n);

    // Randomized sessions
    rcv_rand = 1'b1;
    for (int s = 0; s < 30; s++) begin
      rdy_mode = $urandom_range(0, 2);
      tik_mode = $urandom_range(1, 2);
      cfg_vp   = $urandom_range(40, 100);
      ack_at   = $urandom_range(0, 25);
      do_start($urandom_range(0, 6), $urandom_range(0, 3));
      k = 0; n = 0; fin = 1'b0;
      while (!fin && n < 600) begin
        if (state == 3'd2) begin
          if (k == ack_at) begin
            recv_tvalid = 1'b1; recv_tready = 1'b1; recv_tdata = '1;
          end
          k++;
        end
        if ($urandom_range(0, 199) == 0) abort = 1'b1;
        cycle();
        abort = 1'b0;
        n++;
        if (state == 3'd0 || state == 3'd6) fin = 1'b1;
      end
      chk("rnd_session_end", 64'(fin), 64'd1);
      if (!fin) begin rst = 1'b1; cycle(); rst = 1'b0; end
    end
    rcv_rand = 1'b0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
